// File: rtl/otter_ctrl_fsm.sv
// Multicycle control unit for the OTTER RV32I core: fetch/execute/writeback sequencing,
// IR decode into ALU_FUN and datapath selects, memory handshake and interrupt entry/MRET.
module otter_ctrl_fsm (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] IR,
  input  logic        BR_EQ,
  input  logic        BR_LT,
  input  logic        BR_LTU,
  input  logic        INTR,
  input  logic        MIE,
  input  logic        MEM_RDY,
  output logic [3:0]  ALU_FUN,
  output logic        ALU_SRCA,
  output logic [1:0]  ALU_SRCB,
  output logic [2:0]  PC_SOURCE,
  output logic        PC_WRITE,
  output logic        REG_WRITE,
  output logic [1:0]  RF_WR_SEL,
  output logic        MEM_RDEN1,
  output logic        MEM_RDEN2,
  output logic        MEM_WE2,
  output logic        CSR_WE,
  output logic        INT_TAKEN,
  output logic        MRET_EXEC
);

  localparam logic [1:0] RESET_STATE = 2'b00;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcSystem = 7'b1110011;

  localparam logic [31:0] InsnMret = 32'h3020_0073;

  typedef enum logic [1:0] {
    StFetch = 2'b00,
    StExec  = 2'b01,
    StWb    = 2'b10,
    StIntr  = 2'b11
  } state_e;

  state_e state_q, state_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       br_cond;
  logic       br_taken;
  logic       done;

  logic [3:0] alu_fun;
  logic       alu_srca;
  logic [1:0] alu_srcb;
  logic [2:0] pc_source;
  logic       pc_write;
  logic       reg_write;
  logic [1:0] rf_wr_sel;
  logic       mem_rden1;
  logic       mem_rden2;
  logic       mem_we2;
  logic       csr_we;
  logic       int_taken;
  logic       mret_exec;

  assign opcode = IR[6:0];
  assign funct3 = IR[14:12];

  // funct3[2:1] picks the comparison, funct3[0] inverts it; 010/011 never branch.
  always_comb begin
    case (funct3[2:1])
      2'b00:   br_cond = BR_EQ;
      2'b10:   br_cond = BR_LT;
      2'b11:   br_cond = BR_LTU;
      default: br_cond = 1'b0;
    endcase
    br_taken = (funct3[2:1] != 2'b01) & (br_cond ^ funct3[0]);
  end

  always_comb begin
    state_d   = state_q;
    done      = 1'b0;
    alu_fun   = 4'b0000;
    alu_srca  = 1'b0;
    alu_srcb  = 2'd0;
    pc_source = 3'd0;
    pc_write  = 1'b0;
    reg_write = 1'b0;
    rf_wr_sel = 2'd0;
    mem_rden1 = 1'b0;
    mem_rden2 = 1'b0;
    mem_we2   = 1'b0;
    csr_we    = 1'b0;
    int_taken = 1'b0;
    mret_exec = 1'b0;

    unique case (state_q)
      StFetch: begin
        mem_rden1 = 1'b1;
        if (MEM_RDY) begin
          state_d = StExec;
        end
      end

      StExec: begin
        done = 1'b1;
        case (opcode)
          OpcOp: begin
            alu_fun   = {IR[30], funct3};
            reg_write = 1'b1;
            rf_wr_sel = 2'd3;
          end
          OpcOpImm: begin
            alu_fun   = {(funct3 == 3'b101) & IR[30], funct3};
            alu_srcb  = 2'd1;
            reg_write = 1'b1;
            rf_wr_sel = 2'd3;
          end
          OpcLui: begin
            alu_fun   = 4'b1001;
            alu_srca  = 1'b1;
            reg_write = 1'b1;
            rf_wr_sel = 2'd3;
          end
          OpcAuipc: begin
            alu_srca  = 1'b1;
            alu_srcb  = 2'd3;
            reg_write = 1'b1;
            rf_wr_sel = 2'd3;
          end
          OpcJal: begin
            pc_source = 3'd3;
            reg_write = 1'b1;
          end
          OpcJalr: begin
            pc_source = 3'd1;
            reg_write = 1'b1;
          end
          OpcBranch: begin
            pc_source = br_taken ? 3'd2 : 3'd0;
          end
          OpcLoad: begin
            alu_srcb  = 2'd1;
            mem_rden2 = 1'b1;
            done      = 1'b0;
            state_d   = StWb;
          end
          OpcStore: begin
            alu_srcb = 2'd2;
            mem_we2  = 1'b1;
            done     = MEM_RDY;
          end
          OpcSystem: begin
            if (IR == InsnMret) begin
              pc_source = 3'd5;
              mret_exec = 1'b1;
            end else if (funct3 == 3'b001) begin
              csr_we    = 1'b1;
              reg_write = 1'b1;
              rf_wr_sel = 2'd1;
            end
          end
          default: ;
        endcase
        pc_write = done;
      end

      StWb: begin
        alu_srcb  = 2'd1;
        mem_rden2 = 1'b1;
        done      = MEM_RDY;
        if (MEM_RDY) begin
          reg_write = 1'b1;
          rf_wr_sel = 2'd2;
          pc_write  = 1'b1;
        end
      end

      StIntr: begin
        pc_write  = 1'b1;
        pc_source = 3'd4;
        int_taken = 1'b1;
        state_d   = StFetch;
      end
    endcase

    // Interrupts are only sampled on the cycle an instruction completes.
    if (done) begin
      state_d = (INTR & MIE) ? StIntr : StFetch;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= state_e'(RESET_STATE);
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs are forced low asynchronously while reset is held.
  assign ALU_FUN   = RST_N ? alu_fun   : 4'b0000;
  assign ALU_SRCA  = RST_N & alu_srca;
  assign ALU_SRCB  = RST_N ? alu_srcb  : 2'd0;
  assign PC_SOURCE = RST_N ? pc_source : 3'd0;
  assign PC_WRITE  = RST_N & pc_write;
  assign REG_WRITE = RST_N & reg_write;
  assign RF_WR_SEL = RST_N ? rf_wr_sel : 2'd0;
  assign MEM_RDEN1 = RST_N & mem_rden1;
  assign MEM_RDEN2 = RST_N & mem_rden2;
  assign MEM_WE2   = RST_N & mem_we2;
  assign CSR_WE    = RST_N & csr_we;
  assign INT_TAKEN = RST_N & int_taken;
  assign MRET_EXEC = RST_N & mret_exec;

endmodule
